mdu_ctrl: RTL
=============

# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts mult/div/mthi/mtlo operations from the E stage and models fixed multi-cycle latency with a busy counter. It owns the HI/LO registers and raises a stall request that holds any multiply/divide-class instruction in D while the unit is occupied. Operands arrive already forwarded from the E-stage bypass muxes.

## Interface
Parameters:
- MUL_CYCLES, 5: busy cycles for mult-class ops (range 1–15).
- DIV_CYCLES, 10: busy cycles for div-class ops (range 1–15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  E-stage instruction is a valid MD op this cycle.
- md_op  in  4  operation code:
  - 0 NOP
  - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MTHI, 6 MTLO
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU
  - other codes NOP.
- src_a  in  32  forwarded rs value.
- src_b  in  32  forwarded rt value.
- d_is_md  in  1  D-stage instruction is mult/div/madd*/msub*/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in flight.
- stall  out  1  combinational stall request to the hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, 4-bit counter cnt.
- IDLE with start=1 and a mult-class op (1, 2, 7–10):
  - Latch the result into 64-bit pending register res.
  - cnt←MUL_CYCLES, go to BUSY.
- IDLE with start=1 and a div-class op (3, 4):
  - Latch res={remainder, quotient}.
  - cnt←DIV_CYCLES, go to BUSY.
- IDLE with start=1 and MTHI/MTLO: write hi or lo ←src_a at that edge. No BUSY.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - {hi, lo}←res unless the pending-discard flag is set.
  - Return to IDLE.
- Arithmetic rules:
  - MULT is a signed 32×32→64 product; MULTU is unsigned. {hi, lo}=product.
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divide by zero (src_b==0): the unit goes BUSY for DIV_CYCLES, then discards the result. hi/lo stay unchanged.
- stall = d_is_md & (busy | (start & md_op ∈ {1,2,3,4,7,8,9,10} & state==IDLE)).
- start while BUSY: ignored, with no state change. The pipeline never issues it because stall is asserted.
- Reset in any state, including mid-operation:
  - Go to IDLE; cnt=0, res=0.
  - hi=0, lo=0, busy=0. The in-flight result is lost.

## Timing
- Reset values: busy=0, stall=0 (given d_is_md=0 or idle), hi=0, lo=0.
- start sampled at the rising edge ending cycle T.
- busy is high in cycles T+1…T+N, where N=MUL_CYCLES or DIV_CYCLES.
- New hi/lo are visible from cycle T+N+1, and busy is low in that cycle.
- MTHI/MTLO: the new value is visible in cycle T+1, and busy stays 0.
- stall is combinational from start, md_op, d_is_md and the state. It is asserted in cycle T itself, so an mfhi directly behind a mult is held.
- An mfhi in D during cycle T+N+1 is not stalled and reads the new hi.
- Operations are back-to-back capable: a new start accepted in cycle T+N+1 re-enters BUSY at that edge.

## Configuration
- MDU_MADD_EN defined:
  - Ops 7–10 are implemented as mult-class ops.
  - MADD/MADDU: res={hi, lo}+product, taking signed or unsigned product respectively. MSUB/MSUBU: res={hi, lo}−product.
  - Accumulation uses the {hi, lo} value at the start edge and is modulo 2^64.
- MDU_MADD_EN undefined:
  - Ops 7–10 are treated as NOP, with no BUSY entry and no stall contribution.
  - The accumulate datapath is not synthesized.

## Test plan
- MULT src_a=0xFFFFFFFD, src_b=5 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU on the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV src_a=0xFFFFFFF9 (−7), src_b=2 → busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- Edge cases: DIV by 0 with hi=0x11, lo=0x22 → after 10 busy cycles, hi=0x11, lo=0x22. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall: start MULT while d_is_md=1 (mfhi) → stall=1 in cycles T…T+5 and 0 in T+6. A start during busy is ignored, and hi/lo hold the first result.
- Reset asserted in cycle T+3 of a DIV → busy, hi and lo go to 0 immediately (asynchronously). No commit occurs afterwards.
- With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0. Next, MSUB 2×3 → {hi, lo}=0x00000000_FFFFFFFA.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl - multiply/divide unit controller
//
// Accepts mult/div/mthi/mtlo operations from the E stage and models a fixed
// multi-cycle latency with a down-counter. The result is computed at the start
// edge and parked in a 64-bit pending register until the counter expires, at
// which point it is committed to HI/LO. A combinational stall request holds
// any multiply/divide-class instruction in D while the unit is occupied.
//
// Configuration:
//   MDU_MADD_EN  when defined, MADD/MADDU/MSUB/MSUBU (ops 7-10) accumulate
//                into {hi, lo}; when undefined those codes decode as NOP and
//                no accumulate datapath is built.
//
// Parameters:
//   MUL_CYCLES   busy cycles for mult-class ops (1..15)
//   DIV_CYCLES   busy cycles for div-class ops  (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   start        E-stage instruction is a valid MD op this cycle
//   md_op[3:0]   operation code (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//                6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP)
//   src_a[31:0]  forwarded rs value
//   src_b[31:0]  forwarded rt value
//   d_is_md      D-stage instruction touches the MDU or HI/LO
//   busy         operation in flight
//   stall        combinational stall request to the hazard unit
//   hi[31:0]     HI register
//   lo[31:0]     LO register
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        discard_q, discard_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // ---------------------------------------------------------------------
    // Operation decode
    // ---------------------------------------------------------------------
    logic is_mul_op;
    logic is_div_op;

    always_comb begin
        is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul_op = is_mul_op || (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                    (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
        is_div_op = (md_op == OP_DIV) || (md_op == OP_DIVU);
    end

    // ---------------------------------------------------------------------
    // Multiplier: operands widened to 64 bits so the low 64 bits of the
    // product are exact for both signed and unsigned interpretations.
    // ---------------------------------------------------------------------
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_sx   = 64'($signed(src_a));
    assign b_sx   = 64'($signed(src_b));
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    logic [63:0] mul_res;

`ifdef MDU_MADD_EN
    logic [63:0] acc_prod;
    logic        acc_sub;

    // Accumulation base is the architectural {hi, lo} at the start edge.
    assign acc_prod = ((md_op == OP_MADD) || (md_op == OP_MSUB)) ? prod_s : prod_u;
    assign acc_sub  = (md_op == OP_MSUB) || (md_op == OP_MSUBU);

    always_comb begin
        if (md_op == OP_MULT) begin
            mul_res = prod_s;
        end else if (md_op == OP_MULTU) begin
            mul_res = prod_u;
        end else if (acc_sub) begin
            mul_res = {hi_q, lo_q} - acc_prod;
        end else begin
            mul_res = {hi_q, lo_q} + acc_prod;
        end
    end
`else
    assign mul_res = (md_op == OP_MULT) ? prod_s : prod_u;
`endif

    // ---------------------------------------------------------------------
    // Divider: signed division is done on magnitudes and the signs are
    // re-applied afterwards. This keeps 0x80000000 / -1 well defined (the
    // quotient wraps back to 0x80000000) and gives truncation toward zero
    // with the remainder following the dividend's sign. A zero divisor is
    // replaced by 1 so the datapath never divides by zero; that result is
    // discarded at commit anyway.
    // ---------------------------------------------------------------------
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    assign div_signed  = (md_op == OP_DIV);
    assign a_neg       = div_signed & src_a[31];
    assign b_neg       = div_signed & src_b[31];
    assign dvd_mag     = a_neg ? (~src_a + 32'd1) : src_a;
    assign dvs_mag     = b_neg ? (~src_b + 32'd1) : src_b;
    assign div_by_zero = (src_b == 32'd0);
    assign dvs_safe    = div_by_zero ? 32'd1 : dvs_mag;
    assign uquot       = dvd_mag / dvs_safe;
    assign urem        = dvd_mag % dvs_safe;
    assign quot        = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    assign rem         = a_neg ? (~urem + 32'd1) : urem;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        discard_d = discard_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul_op) begin
                        res_d     = mul_res;
                        cnt_d     = MUL_CNT;
                        discard_d = 1'b0;
                        state_d   = S_BUSY;
                    end else if (is_div_op) begin
                        res_d     = {rem, quot};
                        cnt_d     = DIV_CNT;
                        discard_d = div_by_zero;
                        state_d   = S_BUSY;
                    end else if (md_op == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end

            S_BUSY: begin
                // A start arriving here is ignored; the hazard unit is
                // already stalling any MD instruction behind us.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!discard_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: the pending result register is cleared on reset along with the
    // rest of the state, so nothing from an aborted operation survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            res_q     <= 64'd0;
            discard_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            discard_q <= discard_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy  = (state_q == S_BUSY);
    // The start term covers cycle T itself, before busy rises, so an
    // mfhi directly behind a mult is held.
    assign stall = d_is_md & (busy | (start & (is_mul_op | is_div_op) & (state_q == S_IDLE)));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
